// File: rtl/grid_mem_sequencer.sv
// Owns the port of a single-bit grid memory: whole-grid engine (CLEAR/FILL/INVERT/COUNT),
// one cell per cycle, with single-cell host access while the engine is idle.
module grid_mem_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned ADDR_H = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [1:0]               i_op,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDR_W+ADDR_H:0]   o_count,
  input  logic                     i_host_req,
  input  logic                     i_host_wr,
  input  logic [ADDR_W-1:0]        i_host_x,
  input  logic [ADDR_H-1:0]        i_host_y,
  input  logic                     i_host_din,
  output logic                     o_host_gnt,
  output logic                     o_host_dout,
  output logic                     o_mem_wr,
  output logic                     o_mem_rd,
  output logic [ADDR_W-1:0]        o_mem_addr_x,
  output logic [ADDR_H-1:0]        o_mem_addr_y,
  output logic                     o_mem_din,
  input  logic                     i_mem_dout
);

  localparam int unsigned CntW = ADDR_W + ADDR_H + 1;
  localparam logic [ADDR_W-1:0] XLast = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_H-1:0] YLast = ADDR_H'(HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [1:0] {
    OpClear  = 2'b00,
    OpFill   = 2'b01,
    OpCount  = 2'b10,
    OpInvert = 2'b11
  } op_e;

  state_e              r_state, w_state_next;
  op_e                 r_op;
  logic [ADDR_W-1:0]   r_x;
  logic [ADDR_H-1:0]   r_y;
  logic [CntW-1:0]     r_count;
  logic                w_last;

  assign w_last  = (r_x == XLast) && (r_y == YLast);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_op    <= OpClear;
      r_x     <= '0;
      r_y     <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_op    <= op_e'(i_op);
            r_x     <= '0;
            r_y     <= '0;
            r_count <= '0;
          end
        end
        StRun: begin
          if (r_op == OpCount) r_count <= r_count + CntW'(i_mem_dout);
          // y is the fast axis; x steps when y wraps
          if (r_y == YLast) begin
            r_y <= '0;
            r_x <= (r_x == XLast) ? '0 : r_x + ADDR_W'(1);
          end else begin
            r_y <= r_y + ADDR_H'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_host_gnt   = 1'b0;
    o_host_dout  = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_addr_x = '0;
    o_mem_addr_y = '0;
    o_mem_din    = 1'b0;
    // Gating on reset keeps an aborted op from touching the cell it was about to write
    if (!i_rst) begin
      case (r_state)
        StIdle: begin
          if (i_start) w_state_next = StRun;
          if (i_host_req) begin
            o_host_gnt   = 1'b1;
            o_mem_wr     = i_host_wr;
            o_mem_rd     = !i_host_wr;
            o_mem_addr_x = i_host_x;
            o_mem_addr_y = i_host_y;
            o_mem_din    = i_host_din;
            o_host_dout  = i_host_wr ? 1'b0 : i_mem_dout;
          end
        end
        StRun: begin
          o_busy       = 1'b1;
          o_mem_addr_x = r_x;
          o_mem_addr_y = r_y;
          if (w_last) w_state_next = StDone;
          case (r_op)
            OpClear: begin
              o_mem_wr  = 1'b1;
              o_mem_din = 1'b0;
            end
            OpFill: begin
              o_mem_wr  = 1'b1;
              o_mem_din = 1'b1;
            end
            OpInvert: begin
              o_mem_rd  = 1'b1;
              o_mem_wr  = 1'b1;
              o_mem_din = ~i_mem_dout;
            end
            OpCount: o_mem_rd = 1'b1;
            default: ;
          endcase
        end
        StDone: begin
          o_busy       = 1'b1;
          o_done       = 1'b1;
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_mem_sequencer.sv
// Bench for grid_mem_sequencer: behavioural grid memory, reference grid and a scoreboard queue
// of expected COUNT results and host read data.
module tb_grid_mem_sequencer;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int AW = 4;
  localparam int AH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic          busy;
  logic          done;
  logic [AW+AH:0] count;
  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_x;
  logic [AH-1:0] host_y;
  logic          host_din;
  logic          host_gnt;
  logic          host_dout;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr_x;
  logic [AH-1:0] mem_addr_y;
  logic          mem_din;
  logic          mem_dout;

  always #5 clk = ~clk;

  grid_mem_sequencer #(
    .WIDTH (W),
    .HEIGHT(H),
    .ADDR_W(AW),
    .ADDR_H(AH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_op        (op),
    .o_busy      (busy),
    .o_done      (done),
    .o_count     (count),
    .i_host_req  (host_req),
    .i_host_wr   (host_wr),
    .i_host_x    (host_x),
    .i_host_y    (host_y),
    .i_host_din  (host_din),
    .o_host_gnt  (host_gnt),
    .o_host_dout (host_dout),
    .o_mem_wr    (mem_wr),
    .o_mem_rd    (mem_rd),
    .o_mem_addr_x(mem_addr_x),
    .o_mem_addr_y(mem_addr_y),
    .o_mem_din   (mem_din),
    .i_mem_dout  (mem_dout)
  );

  // Grid memory: combinational read, write on the rising edge
  logic mem_q [W][H];
  assign mem_dout = mem_q[mem_addr_x][mem_addr_y];
  always @(posedge clk) if (mem_wr) mem_q[mem_addr_x][mem_addr_y] <= mem_din;

  int n_checks = 0;
  int n_errs   = 0;
  int exp_q[$];
  bit ref_g [W][H];

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcount();
    int s = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) s += int'(ref_g[x][y]);
    return s;
  endfunction

  task automatic apply_ref(input logic [1:0] o);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        case (o)
          2'b00: ref_g[x][y] = 1'b0;
          2'b01: ref_g[x][y] = 1'b1;
          2'b11: ref_g[x][y] = ~ref_g[x][y];
          default: ;
        endcase
  endtask

  task automatic pop_check(input string tag, input int act);
    if (exp_q.size() == 0) check({tag, "_queue_empty"}, 1, 0);
    else check(tag, act, exp_q.pop_front());
  endtask

  // Launch one bulk op; hold_host keeps a host write to (5,5) pending throughout,
  // mess re-asserts start with a toggling op partway through RUN.
  task automatic run_op(input logic [1:0] o, input bit hold_host, input bit mess);
    int n;
    bit got;
    if (o == 2'b10) exp_q.push_back(popcount());
    start = 1'b1;
    op    = o;
    step();
    start = 1'b0;
    n     = 1;
    got   = 1'b0;
    if (hold_host) begin
      host_req = 1'b1;
      host_wr  = 1'b1;
      host_x   = 4'd5;
      host_y   = 4'd5;
      host_din = 1'b0;
    end
    while (n < 400) begin
      if (mess && n >= 50) begin
        start = 1'b1;
        op    = n[0] ? 2'b00 : 2'b01;
      end
      #1;
      if (hold_host) check("gnt_while_busy", int'(host_gnt), 0);
      if (done) begin
        got = 1'b1;
        break;
      end
      step();
      n++;
    end
    check("done_latency", got ? n : -1, 257);
    check("busy_in_done", int'(busy), 1);
    if (o == 2'b10) pop_check("count", int'(count));
    else check("count_non_count_op", int'(count), 0);
    start = 1'b0;
    apply_ref(o);
    step();
    #1;
    check("busy_after_done", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    if (hold_host) begin
      check("gnt_first_idle", int'(host_gnt), 1);
      check("gnt_mem_wr", int'(mem_wr), 1);
      ref_g[5][5] = 1'b0;
      step();
      host_req = 1'b0;
      host_wr  = 1'b0;
    end
    if (mess) begin
      for (int i = 0; i < 3; i++) begin
        step();
        check("no_restart_busy", int'(busy), 0);
        check("no_second_done", int'(done), 0);
      end
    end
  endtask

  task automatic host_op(input bit wr, input logic [AW-1:0] x, input logic [AH-1:0] y,
                         input bit din);
    host_req = 1'b1;
    host_wr  = wr;
    host_x   = x;
    host_y   = y;
    host_din = din;
    #1;
    check("host_gnt", int'(host_gnt), 1);
    check("host_mem_rd", int'(mem_rd), int'(!wr));
    if (!wr) begin
      exp_q.push_back(int'(ref_g[x][y]));
      pop_check($sformatf("host_dout_%0d_%0d", x, y), int'(host_dout));
    end else begin
      ref_g[x][y] = din;
    end
    step();
    host_req = 1'b0;
    host_wr  = 1'b0;
    host_din = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    host_req = 1'b0;
    host_wr  = 1'b0;
    host_x   = '0;
    host_y   = '0;
    host_din = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(count), 0);
    check("rst_gnt", int'(host_gnt), 0);
    check("rst_host_dout", int'(host_dout), 0);
    check("rst_mem_wr", int'(mem_wr), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_addr_x", int'(mem_addr_x), 0);
    check("rst_addr_y", int'(mem_addr_y), 0);
    check("rst_mem_din", int'(mem_din), 0);

    run_op(2'b00, 1'b0, 1'b0);
    run_op(2'b10, 1'b0, 1'b0);

    run_op(2'b01, 1'b0, 1'b0);
    run_op(2'b10, 1'b0, 1'b0);
    host_op(1'b0, 4'd0, 4'd0, 1'b0);
    host_op(1'b0, 4'd15, 4'd15, 1'b0);

    run_op(2'b00, 1'b0, 1'b0);
    host_op(1'b1, 4'd3, 4'd7, 1'b1);
    host_op(1'b1, 4'd0, 4'd0, 1'b1);
    host_op(1'b1, 4'd15, 4'd15, 1'b1);
    host_op(1'b1, 4'd8, 4'd2, 1'b1);
    host_op(1'b1, 4'd8, 4'd3, 1'b1);
    run_op(2'b10, 1'b0, 1'b0);
    run_op(2'b11, 1'b0, 1'b0);
    run_op(2'b10, 1'b0, 1'b0);
    host_op(1'b0, 4'd3, 4'd7, 1'b0);

    run_op(2'b01, 1'b1, 1'b0);
    run_op(2'b10, 1'b0, 1'b0);

    run_op(2'b10, 1'b0, 1'b1);

    // Abort a FILL after cells (0,0)..(0,9) have been written
    run_op(2'b00, 1'b0, 1'b0);
    start = 1'b1;
    op    = 2'b01;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("abort_no_done_early", int'(done), 0);
      step();
    end
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(count), 0);
    for (int y = 0; y < 10; y++) ref_g[0][y] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", int'(done), 0);
      step();
    end
    for (int y = 0; y <= 10; y++) host_op(1'b0, 4'd0, AH'(y), 1'b0);
    run_op(2'b10, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
